auto_exposure: RTL and testbench

AUTO_EXPOSURE -- requirements
Module: auto_exposure

---
 rtl/auto_exposure.sv | 194 +++++++++++++++++++
 tb/tb_auto_exposure.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_exposure.sv
// Auto-exposure gain stage.
// Applies a Q4.4 gain to r/g/b over a two-stage pipeline, measures the mean
// output luma of each frame, and steps the gain once per frame so that the
// mean settles inside a +/-4 band around the requested target.
// Pack layout, MSB first: {clk, hsync, vsync, de, r[7:0], g[7:0], b[7:0], x, y}.
module auto_exposure #(
  parameter logic [11:0] H_ACT = 12'd1280,
  parameter logic [11:0] V_ACT = 12'd720,
  localparam int XW        = $clog2(H_ACT),
  localparam int YW        = $clog2(V_ACT),
  localparam int PACK_SIZE = 3*8 + 4 + XW + YW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [7:0]           target,
  input  logic [PACK_SIZE-1:0] i_pack,
  output logic [PACK_SIZE-1:0] o_pack,
  output logic [7:0]           gain
);

  localparam int NPIX  = int'(H_ACT) * int'(V_ACT);
  localparam int SUM_W = $clog2(NPIX*255 + 1);

  localparam logic [7:0] GAIN_RESET = 8'h10;
  localparam logic [7:0] GAIN_MAX   = 8'h40;
  localparam logic [7:0] GAIN_MIN   = 8'h08;

  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, UPDATE} state_t;

  // Unpacked input fields
  logic          in_clk, in_hs, in_vs, in_de;
  logic [7:0]    in_r, in_g, in_b;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;

  assign {in_clk, in_hs, in_vs, in_de, in_r, in_g, in_b, in_x, in_y} = i_pack;

  // Stage 1: raw products, raw pixel copy for bypass, delayed timing
  logic          s1_hs, s1_vs, s1_de, s1_en;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic [7:0]    s1_r, s1_g, s1_b;
  logic [15:0]   s1_pr, s1_pg, s1_pb;

  // Stage 2: final output pixel and timing
  logic          s2_hs, s2_vs, s2_de;
  logic [XW-1:0] s2_x;
  logic [YW-1:0] s2_y;
  logic [7:0]    s2_r, s2_g, s2_b;

  // Frame measurement
  logic             vs_prev;
  logic             frame_end;
  logic [9:0]       luma_full;
  logic [7:0]       luma;
  logic [SUM_W-1:0] sum, sum_q, lo_q, hi_q;
  logic [7:0]       band_lo, band_hi;
  state_t           state, state_next;

  // Drop the fractional nibble of a Q4.4 product and clip to 8 bits
  function automatic logic [7:0] sat8(input logic [15:0] p);
    return (p[15:12] != 4'd0) ? 8'hFF : p[11:4];
  endfunction

  // Stage 1: multiply every component by the current gain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_de <= 1'b0;
      s1_en <= 1'b0;
      s1_x  <= '0;
      s1_y  <= '0;
      s1_r  <= 8'd0;
      s1_g  <= 8'd0;
      s1_b  <= 8'd0;
      s1_pr <= 16'd0;
      s1_pg <= 16'd0;
      s1_pb <= 16'd0;
    end else begin
      s1_hs <= in_hs;
      s1_vs <= in_vs;
      s1_de <= in_de;
      s1_en <= en;
      s1_x  <= in_x;
      s1_y  <= in_y;
      s1_r  <= in_r;
      s1_g  <= in_g;
      s1_b  <= in_b;
      s1_pr <= in_r * gain;
      s1_pg <= in_g * gain;
      s1_pb <= in_b * gain;
    end
  end

  // Stage 2: saturate the gained value, or pass the raw pixel when bypassed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_hs <= 1'b0;
      s2_vs <= 1'b0;
      s2_de <= 1'b0;
      s2_x  <= '0;
      s2_y  <= '0;
      s2_r  <= 8'd0;
      s2_g  <= 8'd0;
      s2_b  <= 8'd0;
    end else begin
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_de <= s1_de;
      s2_x  <= s1_x;
      s2_y  <= s1_y;
      s2_r  <= s1_en ? sat8(s1_pr) : s1_r;
      s2_g  <= s1_en ? sat8(s1_pg) : s1_g;
      s2_b  <= s1_en ? sat8(s1_pb) : s1_b;
    end
  end

  assign o_pack = {in_clk, s2_hs, s2_vs, s2_de, s2_r, s2_g, s2_b, s2_x, s2_y};

  // Luma of the outgoing pixel and frame-end detection on the delayed vsync
  always_comb begin
    luma_full = {2'b00, s2_r} + {1'b0, s2_g, 1'b0} + {2'b00, s2_b};
    luma      = 8'(luma_full >> 2);
    frame_end = s2_vs & ~vs_prev;
    band_lo   = (target >= 8'd4)   ? (target - 8'd4) : 8'd0;
    band_hi   = (target <= 8'd251) ? (target + 8'd4) : 8'd255;
  end

  // Remember the previous delayed vsync for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vs_prev <= 1'b0;
    else       vs_prev <= s2_vs;
  end

  // Control state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: the frame end that leaves IDLE only arms measurement
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_end) state_next = ACCUM;
      ACCUM:   if (frame_end) state_next = EVAL;
      EVAL:    state_next = UPDATE;
      UPDATE:  state_next = ACCUM;
      default: state_next = IDLE;
    endcase
  end

  // Luma accumulator; a frame end snapshots the total and restarts the sum
  // with the current pixel so nothing is lost across the boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum   <= '0;
      sum_q <= '0;
    end else if (state == IDLE) begin
      sum <= '0;
    end else if (state == ACCUM && frame_end) begin
      sum_q <= sum;
      sum   <= s2_de ? SUM_W'(luma) : '0;
    end else if (s2_de) begin
      sum <= sum + SUM_W'(luma);
    end
  end

  // Acceptance band scaled to a whole-frame sum; target is sampled only here
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (state == EVAL) begin
      lo_q <= SUM_W'(band_lo) * SUM_W'(NPIX);
      hi_q <= SUM_W'(band_hi) * SUM_W'(NPIX);
    end
  end

  // One gain step per frame, clamped to the 0.5 .. 4.0 range
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gain <= GAIN_RESET;
    end else if (state == UPDATE && en) begin
      if (sum_q < lo_q)
        gain <= (gain >= GAIN_MAX) ? GAIN_MAX : gain + 8'd1;
      else if (sum_q > hi_q)
        gain <= (gain <= GAIN_MIN) ? GAIN_MIN : gain - 8'd1;
    end
  end

endmodule

// File: tb/tb_auto_exposure.sv
// Directed bench for auto_exposure using a small 8x4 frame.
module tb_auto_exposure;

  localparam logic [11:0] H = 12'd8;
  localparam logic [11:0] V = 12'd4;
  localparam int NPIX = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  target = 8'd128;
  logic        p_hs, p_vs, p_de;
  logic [7:0]  p_r, p_g, p_b;
  logic [2:0]  p_x;
  logic [1:0]  p_y;
  logic [32:0] i_pack, o_pack;
  logic [7:0]  gain;

  logic        o_clk, o_hs, o_vs, o_de;
  logic [7:0]  o_r, o_g, o_b;
  logic [2:0]  o_x;
  logic [1:0]  o_y;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_gain = 8'h10;
  bit          skip_next = 1'b1;
  bit          did200 = 1'b0;

  typedef struct {
    logic       en, hs, de;
    logic [7:0] r, g, b;
    logic [2:0] x;
    logic [1:0] y;
    logic [7:0] er, eg, eb;
  } vec_t;
  vec_t tbl[8];

  assign i_pack = {clk, p_hs, p_vs, p_de, p_r, p_g, p_b, p_x, p_y};
  assign {o_clk, o_hs, o_vs, o_de, o_r, o_g, o_b, o_x, o_y} = o_pack;

  auto_exposure #(.H_ACT(H), .V_ACT(V)) dut (
    .clk(clk), .rstn(rstn), .en(en), .target(target),
    .i_pack(i_pack), .o_pack(o_pack), .gain(gain)
  );

  always #5 clk = ~clk;

  // Expected output component for a gray input at a given gain
  function automatic logic [7:0] model_pix(input logic [7:0] v, input logic [7:0] g, input bit e);
    int p;
    p = (int'(v) * int'(g)) >> 4;
    if (!e) return v;
    return (p > 255) ? 8'd255 : 8'(p);
  endfunction

  // Expected gain after a full uniform frame
  function automatic logic [7:0] model_gain(input logic [7:0] v, input logic [7:0] g,
                                            input logic [7:0] t, input bit e, input bit has_de);
    int y, s, lo, hi;
    if (!e) return g;
    y  = has_de ? int'(model_pix(v, g, 1'b1)) : 0;
    s  = NPIX * y;
    lo = ((int'(t) >= 4) ? int'(t) - 4 : 0) * NPIX;
    hi = ((int'(t) <= 251) ? int'(t) + 4 : 255) * NPIX;
    if (s < lo) return (g >= 8'h40) ? 8'h40 : g + 8'd1;
    if (s > hi) return (g <= 8'h08) ? 8'h08 : g - 8'd1;
    return g;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic hs, input logic vs, input logic de,
                                input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic [2:0] x, input logic [1:0] y);
    p_hs = hs; p_vs = vs; p_de = de;
    p_r = r; p_g = g; p_b = b;
    p_x = x; p_y = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'd0, 2'd0);
  endtask

  // One frame of a uniform gray level, then vsync and blanking long enough
  // for the gain update to land before the next frame
  task automatic run_frame(input logic [7:0] v, input bit with_de);
    int idx;
    idx = 0;
    for (int yy = 0; yy < 4; yy++) begin
      for (int xx = 0; xx < 8; xx++) begin
        apply_stimulus(xx == 7, 1'b0, with_de, v, v, v, 3'(xx), 2'(yy));
        tick();
        if (idx == 4 && with_de) begin
          check_output("frame_pix_r", o_r, model_pix(v, exp_gain, en));
          check_output("frame_pix_de", o_de, 1);
        end
        idx++;
      end
    end
    repeat (2) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 3'd0, 2'd0);
      tick();
    end
    idle();
    repeat (6) tick();
    if (skip_next) skip_next = 1'b0;
    else           exp_gain = model_gain(v, exp_gain, target, en, with_de);
    check_output("frame_gain", gain, exp_gain);
  endtask

  // Asynchronous reset pulse taken between clock edges
  task automatic do_reset();
    #2;
    rstn = 1'b0;
    #1;
    check_output("rst_async_gain", gain, 8'h10);
    check_output("rst_async_de", o_de, 0);
    check_output("rst_async_r", o_r, 0);
    tick();
    tick();
    rstn = 1'b1;
    exp_gain  = 8'h10;
    skip_next = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'd100, 8'd0,   8'd255, 3'd0, 2'd0, 8'd193, 8'd0,   8'd255};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'd8,   8'd131, 8'd132, 3'd1, 2'd1, 8'd15,  8'd253, 8'd255};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'd100, 8'd200, 8'd255, 3'd2, 2'd2, 8'd100, 8'd200, 8'd255};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'd133, 8'd1,   8'd16,  3'd3, 2'd3, 8'd255, 8'd1,   8'd31};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd7,   8'd64,  3'd4, 2'd0, 8'd0,   8'd7,   8'd64};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'd64,  8'd64,  8'd64,  3'd5, 2'd1, 8'd124, 8'd124, 8'd124};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'd50,  8'd50,  8'd50,  3'd6, 2'd2, 8'd96,  8'd96,  8'd96};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 8'd255, 8'd128, 8'd2,   3'd7, 2'd3, 8'd255, 8'd248, 8'd3};

    idle();
    tick();
    tick();
    check_output("reset_gain", gain, 8'h10);
    check_output("reset_fields", int'({o_hs, o_vs, o_de, o_r, o_g, o_b, o_x, o_y}), 0);
    rstn = 1'b1;

    // Two-clock latency at unity gain
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'd100, 8'd100, 8'd100, 3'd1, 2'd0);
    tick();
    check_output("lat_1clk_de", o_de, 0);
    idle();
    tick();
    check_output("lat_2clk_de", o_de, 1);
    check_output("lat_2clk_r", o_r, 100);
    check_output("lat_2clk_b", o_b, 100);
    check_output("lat_2clk_x", o_x, 1);
    tick();
    check_output("lat_3clk_de", o_de, 0);

    // First frame end after reset does not update
    run_frame(8'd100, 1'b1);
    check_output("first_frame_gain", gain, 8'h10);
    run_frame(8'd100, 1'b1);
    check_output("second_frame_gain", gain, 8'h11);

    // Reset in the middle of a frame
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'd64, 8'd64, 8'd64, 3'(i), 2'd0);
      tick();
    end
    idle();
    do_reset();
    run_frame(8'd64, 1'b1);
    check_output("midrst_frame1_gain", gain, 8'h10);
    run_frame(8'd64, 1'b1);
    check_output("midrst_frame2_gain", gain, 8'h11);

    // Climb toward the target and settle
    repeat (14) run_frame(8'd64, 1'b1);
    check_output("settle_gain", gain, 8'h1F);
    repeat (3) run_frame(8'd64, 1'b1);
    check_output("settled_hold_gain", gain, 8'h1F);

    // Vector table at gain 0x1F, mixing bypass and gained pixels
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        en = tbl[i].en;
        apply_stimulus(tbl[i].hs, 1'b0, tbl[i].de, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].x, tbl[i].y);
      end else begin
        idle();
      end
      tick();
      if (i >= 1) begin
        check_output("tbl_r", o_r, tbl[i-1].er);
        check_output("tbl_g", o_g, tbl[i-1].eg);
        check_output("tbl_b", o_b, tbl[i-1].eb);
        check_output("tbl_de", o_de, tbl[i-1].de);
        check_output("tbl_hs", o_hs, tbl[i-1].hs);
        check_output("tbl_xy", int'({o_x, o_y}), int'({tbl[i-1].x, tbl[i-1].y}));
      end
    end

    // Bypass freezes gain
    en = 1'b0;
    repeat (2) run_frame(8'd64, 1'b1);
    check_output("bypass_gain", gain, 8'h1F);

    // Adaptation resumes
    en = 1'b1;
    run_frame(8'd70, 1'b1);
    check_output("resume_gain", gain, 8'h1E);
    run_frame(8'd70, 1'b1);
    check_output("resume_hold_gain", gain, 8'h1E);

    // Dark frames drive the gain to the ceiling; saturation probe at 0x20
    for (int k = 0; k < 40 && exp_gain != 8'h40; k++) begin
      run_frame(8'd16, 1'b1);
      if (exp_gain == 8'h20 && !did200) begin
        did200 = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd200, 8'd200, 8'd200, 3'd0, 2'd0);
        tick();
        idle();
        tick();
        check_output("sat200_r", o_r, 255);
        check_output("sat200_g", o_g, 255);
      end
    end
    check_output("sat200_probed", did200, 1);
    check_output("ceiling_gain", gain, 8'h40);
    run_frame(8'd16, 1'b1);
    check_output("ceiling_hold_gain", gain, 8'h40);

    // Bright frames drive the gain to the floor
    do_reset();
    run_frame(8'd250, 1'b1);
    repeat (8) run_frame(8'd250, 1'b1);
    check_output("floor_gain", gain, 8'h08);
    run_frame(8'd250, 1'b1);
    check_output("floor_hold_gain", gain, 8'h08);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'd250, 8'd250, 8'd250, 3'd0, 2'd0);
    tick();
    idle();
    tick();
    check_output("floor_pix", o_r, 125);

    // Inside the hysteresis band nothing moves
    do_reset();
    run_frame(8'd126, 1'b1);
    for (int k = 0; k < 5; k++) begin
      run_frame(8'd126, 1'b1);
      check_output("band_gain", gain, 8'h10);
    end

    // Empty frame counts as dark
    run_frame(8'd0, 1'b0);
    check_output("empty_frame_gain", gain, 8'h11);

    // Lower band clamps at zero: an empty frame is then in band
    target = 8'd2;
    run_frame(8'd0, 1'b0);
    check_output("low_target_gain", gain, 8'h11);

    // Upper band clamps at 255: a full-white frame is then in band
    target = 8'd253;
    run_frame(8'd255, 1'b1);
    check_output("high_target_gain", gain, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
